// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default word width, default stack depth, stack op encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

   localparam int WORD_WIDTH          = 16;
   localparam int STACK_DEPTH_DEFAULT = 8;

   // Resolved stack operation for one clock edge; illegal requests decode to OP_HOLD.
   typedef enum logic [1:0] {
      OP_HOLD    = 2'd0,
      OP_PUSH    = 2'd1,
      OP_POP     = 2'd2,
      OP_REPLACE = 2'd3
   } stack_op;

endpackage

// File: rtl/stack_word.sv
// One WIDTH-bit storage word: load-enabled register with asynchronous clear.
// Latency: d appears on q one clock after an edge with load high.
// Backpressure: none; load is always accepted.
module stack_word #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Capture d when loaded; reset clears the word so an empty stack reads zero.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/register_stack.sv
// LIFO of DEPTH WIDTH-bit words with occupancy count; optional sticky error flags (REGISTER_STACK_ERR_EN).
// Latency: pushed word / post-pop top visible one clock after the request edge; one op per cycle.
// Backpressure: none; push when full and pop when empty are dropped, leaving state untouched.
module register_stack
   import cpu_pkg::*;
#(
   parameter int WIDTH = WORD_WIDTH,
   parameter int DEPTH = STACK_DEPTH_DEFAULT,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
`ifdef REGISTER_STACK_ERR_EN
   ,
   input  logic             err_clear,
   output logic             err_overflow,
   output logic             err_underflow
`endif
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   stack_op          op;
   logic [DEPTH-1:0] load;
   logic [WIDTH-1:0] mem [DEPTH];

   assign empty = (count == '0);
   assign full  = (count == DEPTH_C);

   // Resolve push/pop against occupancy; push+pop on empty degrades to a plain push.
   always_comb begin
      op = OP_HOLD;
      if (push && pop) begin
         op = empty ? OP_PUSH : OP_REPLACE;
      end else if (push) begin
         op = full ? OP_HOLD : OP_PUSH;
      end else if (pop) begin
         op = empty ? OP_HOLD : OP_POP;
      end
   end

   // Storage words: push writes slot count, replace rewrites slot count-1 (the current top).
   for (genvar g = 0; g < DEPTH; g++) begin : g_word
      assign load[g] = ((op == OP_PUSH)    && (count == CW'(g))) ||
                       ((op == OP_REPLACE) && (count == CW'(g + 1)));

      stack_word #(
         .WIDTH (WIDTH)
      ) u_word (
         .clock   (clock),
         .reset_n (reset_n),
         .load    (load[g]),
         .d       (push_data),
         .q       (mem[g])
      );
   end

   // Occupancy counter; only legal ops reach here so it cannot wrap.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else begin
         case (op)
            OP_PUSH: count <= count + CW'(1);
            OP_POP:  count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Top multiplexer driven from registered state only; empty falls through to zero.
   always_comb begin
      top = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (count == CW'(i + 1)) begin
            top = mem[i];
         end
      end
   end

`ifdef REGISTER_STACK_ERR_EN
   logic ovf_evt;
   logic unf_evt;

   assign ovf_evt = push && !pop && full;
   assign unf_evt = pop && !push && empty;

   // Sticky error flags; a same-cycle clear wins over a new set.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else if (err_clear) begin
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         if (ovf_evt) err_overflow  <= 1'b1;
         if (unf_evt) err_underflow <= 1'b1;
      end
   end
`endif

endmodule
